wb_stream_accel_bridge: RTL and testbench

Parametrised Wishbone slave that connects a user-project accelerator (sort, FIR, or any job-based stream engine) to the caravel management bus. It is the successor to the single-word QS bridge. It adds configurable base address, data width and FIFO depths, input/output FIFOs, registered ack with back-pressure stalling, a job-length register, and a control state machine. It sits between the Wishbone user port and one accelerator core.

---
 rtl/wb_stream_accel_bridge.sv | 177 +++++++++++++++++
 tb/tb_wb_stream_accel_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_accel_bridge.sv
// Wishbone slave bridging the management bus to a job-based stream accelerator.
// Provides input/output FIFOs, a job-length register and an IDLE/RUN/DONE controller.
module wb_stream_accel_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h3200_0000,
    parameter int          DATA_WIDTH = 32,
    parameter int          IN_DEPTH   = 16,
    parameter int          OUT_DEPTH  = 16
) (
    input  logic                  wbs_clk_i,
    input  logic                  wbs_rst_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic                  wbs_we_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  acc_start,
    output logic [15:0]           acc_len,
    output logic                  acc_in_valid,
    output logic [DATA_WIDTH-1:0] acc_in_data,
    input  logic                  acc_in_ready,
    input  logic                  acc_out_valid,
    input  logic [DATA_WIDTH-1:0] acc_out_data,
    output logic                  acc_out_ready,
    input  logic                  acc_done
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam logic [IN_AW:0]  IN_FULL  = IN_DEPTH[IN_AW:0];
    localparam logic [OUT_AW:0] OUT_FULL = OUT_DEPTH[OUT_AW:0];

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [7:0] sat8(input logic [15:0] cnt);
        return (cnt > 16'd255) ? 8'hFF : cnt[7:0];
    endfunction

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic                start_q, start_d;
    logic [15:0]         len_q, len_d;
    logic [IN_AW-1:0]    in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    logic [IN_AW:0]      in_cnt_q, in_cnt_d;
    logic [OUT_AW-1:0]   out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic [OUT_AW:0]     out_cnt_q, out_cnt_d;
    logic [DATA_WIDTH-1:0] in_mem_q  [IN_DEPTH];
    logic [DATA_WIDTH-1:0] out_mem_q [OUT_DEPTH];

    logic [11:0] off;
    logic        hit, accept, is_ctrl, is_din, is_dout, is_len;
    logic        in_full, out_empty, clear_req, start_req;
    logic        in_push, in_pop, out_push, out_pop;
    logic [31:0] status, dout_ext;
    logic        unused_bits;

    assign unused_bits   = ^{wbs_sel_i, wbs_dat_i};
    assign in_full       = (in_cnt_q == IN_FULL);
    assign out_empty     = (out_cnt_q == '0);
    assign acc_in_valid  = (in_cnt_q != '0);
    assign acc_in_data   = in_mem_q[in_rptr_q];
    assign acc_out_ready = (out_cnt_q != OUT_FULL);
    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;
    assign acc_start     = start_q;
    assign acc_len       = len_q;

    // Decode: no new access is taken while an ack is being presented.
    always_comb begin
        off     = wbs_adr_i[11:0];
        is_ctrl = (off == 12'h000);
        is_din  = (off == 12'h080);
        is_dout = (off == 12'h084);
        is_len  = (off == 12'h088);
        hit     = wbs_cyc_i && wbs_stb_i && !ack_q && (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
        accept  = hit && !(wbs_we_i && is_din && in_full) && !(!wbs_we_i && is_dout && out_empty);
        clear_req = accept && wbs_we_i && is_ctrl && wbs_dat_i[1];
        start_req = accept && wbs_we_i && is_ctrl && wbs_dat_i[0];
        in_push   = accept && wbs_we_i && is_din;
        out_pop   = accept && !wbs_we_i && is_dout;
        in_pop    = acc_in_valid && acc_in_ready && !clear_req;
        out_push  = acc_out_valid && acc_out_ready && !clear_req;
    end

    always_comb begin
        status        = '0;
        status[0]     = (state_q == S_RUN);
        status[1]     = (state_q == S_DONE);
        status[2]     = (state_q == S_IDLE);
        status[3]     = !in_full;
        status[4]     = !out_empty;
        status[15:8]  = sat8(16'(in_cnt_q));
        status[23:16] = sat8(16'(out_cnt_q));
        dout_ext                   = '0;
        dout_ext[DATA_WIDTH-1:0]   = out_mem_q[out_rptr_q];
    end

    always_comb begin
        ack_d = accept;
        dat_d = '0;
        if (accept && !wbs_we_i) begin
            if (is_ctrl)      dat_d = status;
            else if (is_dout) dat_d = dout_ext;
            else if (is_len)  dat_d = {16'h0000, len_q};
        end
        len_d = (accept && wbs_we_i && is_len) ? wbs_dat_i[15:0] : len_q;

        state_d = state_q;
        start_d = 1'b0;
        if (clear_req) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start_req) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                end
                S_RUN: if (acc_done) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end

        // Clear resets both FIFOs outright; otherwise pointers wrap naturally.
        if (clear_req) begin
            in_wptr_d  = '0;
            in_rptr_d  = '0;
            in_cnt_d   = '0;
            out_wptr_d = '0;
            out_rptr_d = '0;
            out_cnt_d  = '0;
        end else begin
            in_wptr_d  = in_wptr_q + IN_AW'(in_push);
            in_rptr_d  = in_rptr_q + IN_AW'(in_pop);
            in_cnt_d   = in_cnt_q + (IN_AW+1)'(in_push) - (IN_AW+1)'(in_pop);
            out_wptr_d = out_wptr_q + OUT_AW'(out_push);
            out_rptr_d = out_rptr_q + OUT_AW'(out_pop);
            out_cnt_d  = out_cnt_q + (OUT_AW+1)'(out_push) - (OUT_AW+1)'(out_pop);
        end
    end

    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            start_q    <= 1'b0;
            len_q      <= '0;
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_cnt_q   <= '0;
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            start_q    <= start_d;
            len_q      <= len_d;
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            in_cnt_q   <= in_cnt_d;
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    always_ff @(posedge wbs_clk_i) begin
        if (in_push)  in_mem_q[in_wptr_q]   <= wbs_dat_i[DATA_WIDTH-1:0];
        if (out_push) out_mem_q[out_wptr_q] <= acc_out_data;
    end

endmodule

// File: tb/tb_wb_stream_accel_bridge.sv
// Directed bench for wb_stream_accel_bridge (input FIFO depth 4); the bench
// plays both the Wishbone master and the accelerator.
module tb_wb_stream_accel_bridge;

    localparam logic [31:0] BASE = 32'h3200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0, wdat = '0;
    logic [3:0]  sel = 4'hF;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic        ack;
    logic [31:0] rdat;
    logic        acc_start;
    logic [15:0] acc_len;
    logic        in_valid, in_ready = 1'b0;
    logic [31:0] in_data;
    logic        out_valid = 1'b0, out_ready;
    logic [31:0] out_data = '0;
    logic        acc_done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int start_pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (acc_start) start_pulses++;

    wb_stream_accel_bridge #(.BASE_ADDR(BASE), .DATA_WIDTH(32), .IN_DEPTH(4), .OUT_DEPTH(16)) dut (
        .wbs_clk_i(clk), .wbs_rst_i(rst), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_sel_i(sel), .wbs_we_i(we), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_ack_o(ack), .wbs_dat_o(rdat), .acc_start(acc_start), .acc_len(acc_len),
        .acc_in_valid(in_valid), .acc_in_data(in_data), .acc_in_ready(in_ready),
        .acc_out_valid(out_valid), .acc_out_data(out_data), .acc_out_ready(out_ready),
        .acc_done(acc_done)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int max_cyc, output logic [31:0] r, output int c, output bit acked);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        acked = 1'b0; r = '0; c = 0;
        while (!acked && c < max_cyc) begin
            @(posedge clk);
            #1;
            c++;
            if (ack) begin
                acked = 1'b1;
                r = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r; int c; bit a;
        step(3);
        rst = 1'b0;
        n_cmp++;
        if ({ack, rdat, acc_start, in_valid, out_ready, acc_len} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b dat=%h start=%b iv=%b or=%b len=%h want 0/0/0/0/1/0",
                     ack, rdat, acc_start, in_valid, out_ready, acc_len);
        end
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0000_000C || !a) begin
            n_bad++;
            $display("FAIL reset_status: got %h acked=%0d want 0000000c", r, a);
        end
        n_cmp++;
        if (c !== 1) begin
            n_bad++;
            $display("FAIL ack_latency: got %0d cycles want 1", c);
        end
    endtask

    task automatic test_job();
        logic [31:0] r; int c; bit a; int s0; int acks;
        logic [31:0] push_v [4];
        push_v[0] = 32'd3; push_v[1] = 32'd1; push_v[2] = 32'd4; push_v[3] = 32'd2;
        wb_xfer(1'b1, BASE + 32'h88, 32'd4, 10, r, c, a);
        wb_xfer(1'b0, BASE + 32'h88, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'd4) begin n_bad++; $display("FAIL len_readback: got %h want 4", r); end
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            wb_xfer(1'b1, BASE + 32'h80, push_v[i], 10, r, c, a);
            acks += int'(a);
        end
        n_cmp++;
        if (acks !== 4) begin n_bad++; $display("FAIL push_acks: got %0d want 4", acks); end
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0000_0404) begin n_bad++; $display("FAIL status_loaded: got %h want 00000404", r); end
        s0 = start_pulses;
        wb_xfer(1'b1, BASE, 32'h1, 10, r, c, a);
        step(2);
        n_cmp++;
        if (start_pulses - s0 !== 1 || acc_len !== 16'd4) begin
            n_bad++;
            $display("FAIL job_start: got pulses=%0d len=%0d want 1/4", start_pulses - s0, acc_len);
        end
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0000_0401) begin n_bad++; $display("FAIL status_busy: got %h want 00000401", r); end
        in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({in_valid, in_data} !== {1'b1, push_v[i]}) begin
                n_bad++;
                $display("FAIL in_stream_%0d: got v=%b d=%h want 1/%h", i, in_valid, in_data, push_v[i]);
            end
            step(1);
        end
        in_ready = 1'b0;
        n_cmp++;
        if (in_valid !== 1'b0) begin n_bad++; $display("FAIL in_drained: got %b want 0", in_valid); end
        for (int i = 1; i <= 4; i++) begin
            out_valid = 1'b1; out_data = 32'(i);
            step(1);
        end
        out_valid = 1'b0;
        acc_done = 1'b1;
        step(1);
        acc_done = 1'b0;
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0004_001A) begin n_bad++; $display("FAIL status_done: got %h want 0004001a", r); end
        for (int i = 1; i <= 4; i++) begin
            wb_xfer(1'b0, BASE + 32'h84, 32'h0, 10, r, c, a);
            n_cmp++;
            if (r !== 32'(i) || !a) begin n_bad++; $display("FAIL data_out_%0d: got %h want %h", i, r, 32'(i)); end
        end
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0000_000A) begin n_bad++; $display("FAIL status_drained: got %h want 0000000a", r); end
    endtask

    task automatic test_in_stall();
        logic [31:0] r; int c; bit a; bit got;
        for (int i = 0; i < 4; i++) wb_xfer(1'b1, BASE + 32'h80, 32'h10 + 32'(i), 10, r, c, a);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h80; wdat = 32'h14;
        got = 1'b0;
        repeat (5) begin
            step(1);
            if (ack) got = 1'b1;
        end
        n_cmp++;
        if (got !== 1'b0) begin n_bad++; $display("FAIL in_full_stall: got ack=%b want 0", got); end
        n_cmp++;
        if (in_data !== 32'h10) begin n_bad++; $display("FAIL in_head: got %h want 00000010", in_data); end
        in_ready = 1'b1;
        step(1);
        in_ready = 1'b0;
        c = 0;
        while (!got && c < 4) begin
            step(1);
            c++;
            if (ack) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n_cmp++;
        if (got !== 1'b1 || c !== 1) begin
            n_bad++;
            $display("FAIL in_stall_release: got ack=%b after %0d cycles want 1 after 1", got, c);
        end
        n_cmp++;
        if (in_data !== 32'h11) begin n_bad++; $display("FAIL in_head_after_pop: got %h want 00000011", in_data); end
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0000_0402) begin n_bad++; $display("FAIL status_in_full: got %h want 00000402", r); end
    endtask

    task automatic test_out_stall();
        logic [31:0] r; int c; bit a; bit got;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h84;
        got = 1'b0;
        repeat (5) begin
            step(1);
            if (ack) got = 1'b1;
        end
        n_cmp++;
        if (got !== 1'b0) begin n_bad++; $display("FAIL out_empty_stall: got ack=%b want 0", got); end
        out_valid = 1'b1; out_data = 32'hABCD;
        step(1);
        out_valid = 1'b0;
        n_cmp++;
        if (ack !== 1'b0) begin n_bad++; $display("FAIL out_ack_n1: got %b want 0", ack); end
        step(1);
        n_cmp++;
        if ({ack, rdat} !== {1'b1, 32'h0000_ABCD}) begin
            n_bad++;
            $display("FAIL out_ack_n2: got ack=%b dat=%h want 1/0000abcd", ack, rdat);
        end
        cyc = 1'b0; stb = 1'b0;
        step(1);
        n_cmp++;
        if ({ack, rdat} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL single_ack: got ack=%b dat=%h want 0/0", ack, rdat);
        end
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0000_0402) begin n_bad++; $display("FAIL status_out_popped: got %h want 00000402", r); end
    endtask

    task automatic test_clear();
        logic [31:0] r; int c; bit a; int s0;
        s0 = start_pulses;
        wb_xfer(1'b1, BASE, 32'h1, 10, r, c, a);
        out_valid = 1'b1; out_data = 32'h7;
        step(1);
        out_valid = 1'b0;
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0001_0411 || start_pulses - s0 !== 1) begin
            n_bad++;
            $display("FAIL status_pre_clear: got %h pulses=%0d want 00010411/1", r, start_pulses - s0);
        end
        step(1);
        acc_done = 1'b1; out_valid = 1'b1; out_data = 32'h9;
        wb_xfer(1'b1, BASE, 32'h2, 10, r, c, a);
        acc_done = 1'b0; out_valid = 1'b0;
        n_cmp++;
        if (a !== 1'b1 || c !== 1) begin n_bad++; $display("FAIL clear_ack: got acked=%b cycles=%0d want 1/1", a, c); end
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0000_000C) begin n_bad++; $display("FAIL status_cleared: got %h want 0000000c", r); end
        n_cmp++;
        if ({in_valid, out_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL fifos_cleared: got iv=%b or=%b want 0/1", in_valid, out_ready);
        end
        wb_xfer(1'b0, BASE + 32'h88, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'd4) begin n_bad++; $display("FAIL len_kept: got %h want 4", r); end
    endtask

    task automatic test_start_in_run();
        logic [31:0] r; int c; bit a; int s0;
        s0 = start_pulses;
        wb_xfer(1'b1, BASE, 32'h1, 10, r, c, a);
        wb_xfer(1'b1, BASE, 32'h1, 10, r, c, a);
        step(2);
        n_cmp++;
        if (a !== 1'b1 || start_pulses - s0 !== 1) begin
            n_bad++;
            $display("FAIL start_in_run: got acked=%b pulses=%0d want 1/1", a, start_pulses - s0);
        end
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0000_0009) begin n_bad++; $display("FAIL status_run: got %h want 00000009", r); end
        acc_done = 1'b1;
        step(1);
        acc_done = 1'b0;
        wb_xfer(1'b0, BASE, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0000_000A) begin n_bad++; $display("FAIL status_done2: got %h want 0000000a", r); end
    endtask

    task automatic test_unmapped();
        logic [31:0] r; int c; bit a;
        step(1);
        wb_xfer(1'b0, BASE + 32'hFC, 32'h0, 10, r, c, a);
        n_cmp++;
        if ({a, r} !== {1'b1, 32'h0} || c !== 1) begin
            n_bad++;
            $display("FAIL unmapped_read: got acked=%b dat=%h cycles=%0d want 1/0/1", a, r, c);
        end
        wb_xfer(1'b1, BASE + 32'hFC, 32'hFFFF_FFFF, 10, r, c, a);
        wb_xfer(1'b0, BASE + 32'h88, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'd4) begin n_bad++; $display("FAIL unmapped_write_dropped: got %h want 4", r); end
        wb_xfer(1'b1, BASE + 32'h88, 32'h1234_5678, 10, r, c, a);
        wb_xfer(1'b0, BASE + 32'h88, 32'h0, 10, r, c, a);
        n_cmp++;
        if (r !== 32'h0000_5678 || acc_len !== 16'h5678) begin
            n_bad++;
            $display("FAIL len_16bit: got %h len=%h want 00005678/5678", r, acc_len);
        end
        wb_xfer(1'b0, 32'h3300_0000, 32'h0, 20, r, c, a);
        n_cmp++;
        if (a !== 1'b0) begin n_bad++; $display("FAIL outside_window: got acked=%b want 0", a); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; int c; bit a;
        wb_xfer(1'b1, BASE + 32'h80, 32'h55, 10, r, c, a);
        step(1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
        step(1);
        n_cmp++;
        if (ack !== 1'b1) begin n_bad++; $display("FAIL mid_ack: got %b want 1", ack); end
        rst = 1'b1;
        step(1);
        cyc = 1'b0; stb = 1'b0;
        n_cmp++;
        if ({ack, in_valid, acc_len} !== {1'b0, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_mid: got ack=%b iv=%b len=%h want 0/0/0", ack, in_valid, acc_len);
        end
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_job();
        test_in_stall();
        test_out_stall();
        test_clear();
        test_start_in_run();
        test_unmapped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
